// File: rtl/fetch_unit_pkg.sv
// Shared fetch types and constants, also used by the instruction memory.
package fetch_unit_pkg;

    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam int unsigned DEFAULT_MEM_SIZE = 2048;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // 65-bit compare so an address near 2^64 never wraps into the legal range
    function automatic logic addr_legal(input logic [63:0] addr, input logic [64:0] mem_size);
        return (addr[1:0] == 2'b00) && (({1'b0, addr} + 65'd3) < mem_size);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs for decode.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head_entry
);

    fetch_entry_t entries [2];
    logic         head;
    logic         tail;

    // With two slots, head + count wraps back onto head when full; that slot is
    // exactly the one freed by a concurrent pop.
    assign tail       = head ^ count[0];
    assign head_entry = entries[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 2'd0;
            head       <= 1'b0;
            entries[0] <= '0;
            entries[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            if (push)
                entries[tail] <= push_entry;
            if (pop)
                head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, 2-entry buffer, redirect and fault FSM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP,
    parameter int unsigned MEM_SIZE = DEFAULT_MEM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_data,
    input  logic        branch_valid,
    input  logic [63:0] branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [63:0] out_pc,
    output logic        fault
);

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_SIZE);

    fetch_state_t state, state_next;
    logic [63:0]  pc;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t fetched;
    logic         pc_legal;
    logic         target_legal;
    logic         capture;
    logic         pop;

    assign pc_legal     = addr_legal(pc, MEM_LIMIT);
    assign target_legal = addr_legal(branch_target, MEM_LIMIT);

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready && !branch_valid;
    // A full buffer may still capture when the head leaves on the same edge
    assign capture   = (state == RUN) && !branch_valid && pc_legal &&
                       ((count != 2'd2) || pop);

    assign fetched.pc          = pc;
    assign fetched.instruction = imem_data;

    always_comb begin
        state_next = state;
        if (branch_valid)
            state_next = target_legal ? RUN : FAULT;
        else if ((state == RUN) && !pc_legal)
            state_next = FAULT;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (branch_valid)
            pc <= branch_target;
        else if (capture)
            pc <= pc + 64'(PC_STEP);
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (capture),
        .pop        (pop),
        .flush      (branch_valid),
        .push_entry (fetched),
        .count      (count),
        .head_entry (head)
    );

    assign imem_address    = pc;
    assign out_pc          = head.pc;
    assign out_instruction = head.instruction;
    assign fault           = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table, boundary sequence and random redirects against a queue model.
module tb_fetch_unit;

    localparam logic [31:0] W0  = 32'h8b1f03e5;
    localparam logic [31:0] W1  = 32'hf84000a4;
    localparam logic [31:0] W2  = 32'hd503201f;
    localparam logic [31:0] W16 = 32'haa0103e0;
    localparam logic [31:0] W17 = 32'hb4000080;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_address;
    logic [31:0] imem_data;
    logic        branch_valid;
    logic [63:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [63:0] out_pc;
    logic        fault;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(64'h0), .PC_STEP(4), .MEM_SIZE(2048)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .fault           (fault)
    );

    logic [31:0] mem [512];
    assign imem_data = (imem_address < 64'd2048) ? mem[imem_address[10:2]] : 32'hdeadbeef;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < 64'd2048)
            return mem[a[10:2]];
        return 32'hdeadbeef;
    endfunction

    // Reference model: PC, fault flag and a queue of buffered instructions
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc    = 64'h0;
    logic        m_fault = 1'b0;
    int          checks  = 0;
    int          errors  = 0;

    function automatic logic legal(input logic [63:0] a);
        logic [64:0] last;
        last = {1'b0, a} + 65'd3;
        return (a % 64'd4 == 64'd0) && (last < 65'd2048);
    endfunction

    task automatic model_edge(input logic r, input logic bv, input logic [63:0] tgt,
                              input logic rdy);
        logic popped;
        logic cap;
        ent_t e;
        if (r) begin
            m_pc = 64'h0;
            m_q.delete();
            m_fault = 1'b0;
        end else if (bv) begin
            m_q.delete();
            m_pc = tgt;
            m_fault = !legal(tgt);
        end else begin
            popped = (m_q.size() != 0) && rdy;
            cap = !m_fault && legal(m_pc) && ((m_q.size() < 2) || popped);
            e.pc = m_pc;
            e.ins = mem_word(m_pc);
            if (popped)
                void'(m_q.pop_front());
            if (cap) begin
                m_q.push_back(e);
                m_pc = m_pc + 64'd4;
            end else if (!m_fault && !legal(m_pc)) begin
                m_fault = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        logic        ev;
        logic [63:0] epc;
        logic [31:0] eins;
        ev   = (m_q.size() != 0);
        epc  = ev ? m_q[0].pc : 64'h0;
        eins = ev ? m_q[0].ins : 32'h0;
        checks++;
        if (out_valid !== ev || fault !== m_fault || imem_address !== m_pc ||
            (ev && (out_pc !== epc || out_instruction !== eins))) begin
            errors++;
            $display("FAIL model t=%0t: valid %b want %b, pc %h want %h, ins %h want %h, addr %h want %h, fault %b want %b",
                     $time, out_valid, ev, out_pc, epc, out_instruction, eins,
                     imem_address, m_pc, fault, m_fault);
        end
    endtask

    task automatic cycle(input logic r, input logic bv, input logic [63:0] tgt, input logic rdy);
        reset = r;
        branch_valid = bv;
        branch_target = tgt;
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, bv, tgt, rdy);
        @(negedge clk);
        compare_model();
    endtask

    task automatic expect_state(input string name, input logic ev, input logic [63:0] epc,
                                input logic [63:0] eaddr, input logic ef);
        checks++;
        if (out_valid !== ev || imem_address !== eaddr || fault !== ef ||
            (ev && out_pc !== epc)) begin
            errors++;
            $display("FAIL %s: valid %b want %b, pc %h want %h, addr %h want %h, fault %b want %b",
                     name, out_valid, ev, out_pc, epc, imem_address, eaddr, fault, ef);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        bv;
        logic [63:0] tgt;
        logic        rdy;
        logic        ev;
        logic [63:0] epc;
        logic [31:0] eins;
        logic [63:0] eaddr;
        logic        ef;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic bv, input logic [63:0] tgt,
                                input logic rdy, input logic ev, input logic [63:0] epc,
                                input logic [31:0] eins, input logic [63:0] eaddr,
                                input logic ef);
        vec_t v;
        v.rst = rst; v.bv = bv; v.tgt = tgt; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eins = eins; v.eaddr = eaddr; v.ef = ef;
        return v;
    endfunction

    vec_t vt [24];

    initial begin
        for (int i = 0; i < 512; i++)
            mem[i] = $urandom;
        mem[0]  = W0;
        mem[1]  = W1;
        mem[2]  = W2;
        mem[16] = W16;
        mem[17] = W17;
        reset = 1'b1;
        branch_valid = 1'b0;
        branch_target = 64'h0;
        out_ready = 1'b0;

        // reset release with ready high: 0x0 then 0x4
        vt[0]  = mk(1, 0, 64'h0,  1, 0, 64'h0,  32'h0, 64'h0,  0);
        vt[1]  = mk(0, 0, 64'h0,  1, 1, 64'h0,  W0,    64'h4,  0);
        vt[2]  = mk(0, 0, 64'h0,  1, 1, 64'h4,  W1,    64'h8,  0);
        // ready low: fill to two entries, address frozen at 0x8, then drain
        vt[3]  = mk(1, 0, 64'h0,  1, 0, 64'h0,  32'h0, 64'h0,  0);
        vt[4]  = mk(0, 0, 64'h0,  0, 1, 64'h0,  W0,    64'h4,  0);
        vt[5]  = mk(0, 0, 64'h0,  0, 1, 64'h0,  W0,    64'h8,  0);
        vt[6]  = mk(0, 0, 64'h0,  0, 1, 64'h0,  W0,    64'h8,  0);
        vt[7]  = mk(0, 0, 64'h0,  0, 1, 64'h0,  W0,    64'h8,  0);
        vt[8]  = mk(0, 0, 64'h0,  0, 1, 64'h0,  W0,    64'h8,  0);
        vt[9]  = mk(0, 0, 64'h0,  1, 1, 64'h4,  W1,    64'hc,  0);
        vt[10] = mk(0, 0, 64'h0,  1, 1, 64'h8,  W2,    64'h10, 0);
        // redirect to 0x40 while 0x4 is offered: one bubble
        vt[11] = mk(1, 0, 64'h0,  1, 0, 64'h0,  32'h0, 64'h0,  0);
        vt[12] = mk(0, 0, 64'h0,  1, 1, 64'h0,  W0,    64'h4,  0);
        vt[13] = mk(0, 0, 64'h0,  1, 1, 64'h4,  W1,    64'h8,  0);
        vt[14] = mk(0, 1, 64'h40, 1, 0, 64'h0,  32'h0, 64'h40, 0);
        vt[15] = mk(0, 0, 64'h0,  1, 1, 64'h40, W16,   64'h44, 0);
        vt[16] = mk(0, 0, 64'h0,  1, 1, 64'h44, W17,   64'h48, 0);
        // misaligned target faults until a legal redirect
        vt[17] = mk(0, 1, 64'h42, 1, 0, 64'h0,  32'h0, 64'h42, 1);
        vt[18] = mk(0, 0, 64'h0,  1, 0, 64'h0,  32'h0, 64'h42, 1);
        vt[19] = mk(0, 0, 64'h0,  1, 0, 64'h0,  32'h0, 64'h42, 1);
        vt[20] = mk(0, 1, 64'h0,  1, 0, 64'h0,  32'h0, 64'h0,  0);
        vt[21] = mk(0, 0, 64'h0,  1, 1, 64'h0,  W0,    64'h4,  0);
        // reset wins over a simultaneous redirect
        vt[22] = mk(1, 1, 64'h40, 1, 0, 64'h0,  32'h0, 64'h0,  0);
        vt[23] = mk(0, 0, 64'h0,  0, 1, 64'h0,  W0,    64'h4,  0);

        for (int i = 0; i < 24; i++) begin
            cycle(vt[i].rst, vt[i].bv, vt[i].tgt, vt[i].rdy);
            checks++;
            if (out_valid !== vt[i].ev || imem_address !== vt[i].eaddr || fault !== vt[i].ef ||
                (vt[i].ev && (out_pc !== vt[i].epc || out_instruction !== vt[i].eins))) begin
                errors++;
                $display("FAIL vec%0d: valid %b want %b, pc %h want %h, ins %h want %h, addr %h want %h, fault %b want %b",
                         i, out_valid, vt[i].ev, out_pc, vt[i].epc, out_instruction, vt[i].eins,
                         imem_address, vt[i].eaddr, fault, vt[i].ef);
            end
            if (vt[i].rst) begin
                checks++;
                if (out_pc !== 64'h0 || out_instruction !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_head%0d: pc %h ins %h want 0 and 0", i, out_pc, out_instruction);
                end
            end
        end

        // end-of-memory: 0x7FC is the last legal word, 0x800 faults while entries drain
        cycle(0, 1, 64'h7f0, 0);
        expect_state("end_redirect", 0, 64'h0, 64'h7f0, 0);
        cycle(0, 0, 64'h0, 0);
        cycle(0, 0, 64'h0, 0);
        expect_state("end_full", 1, 64'h7f0, 64'h7f8, 0);
        cycle(0, 0, 64'h0, 1);
        cycle(0, 0, 64'h0, 1);
        expect_state("end_last_legal", 1, 64'h7f8, 64'h800, 0);
        cycle(0, 0, 64'h0, 1);
        expect_state("end_fault_drain", 1, 64'h7fc, 64'h800, 1);
        cycle(0, 0, 64'h0, 1);
        expect_state("end_fault_empty", 0, 64'h0, 64'h800, 1);
        cycle(0, 0, 64'h0, 1);
        expect_state("end_fault_hold", 0, 64'h0, 64'h800, 1);
        cycle(0, 1, 64'h0, 1);
        expect_state("end_recover", 0, 64'h0, 64'h0, 0);
        cycle(0, 0, 64'h0, 1);
        expect_state("end_resume", 1, 64'h0, 64'h4, 0);

        for (int n = 0; n < 2000; n++) begin
            logic        r;
            logic        bv;
            logic        rdy;
            logic [63:0] tgt;
            r   = ($urandom_range(0, 99) == 0);
            bv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: tgt = 64'($urandom_range(0, 511)) << 2;
                1: tgt = 64'h7f0 + (64'($urandom_range(0, 7)) << 2);
                2: tgt = (64'($urandom_range(0, 511)) << 2) | 64'($urandom_range(1, 3));
                3: tgt = {$urandom, $urandom};
                default: tgt = 64'hffff_ffff_ffff_fffc;
            endcase
            cycle(r, bv, tgt, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that drives the byte-addressed, little-endian, combinational-read instruction memory and delivers 32-bit instructions with their PCs to decode over a valid/ready handshake. It owns the PC register, a 2-entry fetch buffer, branch redirect/flush and an out-of-range/misalignment fault state. It sits between the instruction memory and the decode stage of the single-cycle and pipelined cores.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- PC_STEP, 4, byte increment between sequential fetches (16 for the pipelined memory layout)
- MEM_SIZE, 2048, instruction memory size in bytes; legal fetch needs pc + 3 < MEM_SIZE
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- imem_address  output  64  fetch byte address to instruction memory, equals PC register
- imem_data  input  32  instruction word returned combinationally for imem_address
- branch_valid  input  1  redirect request, one-cycle pulse
- branch_target  input  64  redirect byte address
- out_valid  output  1  buffer head holds an instruction
- out_ready  input  1  decode accepts head this cycle
- out_instruction  output  32  head instruction
- out_pc  output  64  head PC
- fault  output  1  fetch halted on illegal address

## Operation
- State machine RUN / FAULT. Reset: state RUN, pc = RESET_PC, buffer count 0, out_valid 0, out_pc 0, out_instruction 0, fault 0.
- Capture condition (RUN only): no branch_valid, pc legal, and count < 2 or (count == 2 and out_valid and out_ready). On capture push {pc, imem_data}, pc += PC_STEP (64-bit wrap, no saturation).
- Pop: out_valid and out_ready with no branch_valid; head advances.
- Push and pop in same edge: count unchanged, order preserved.
- Legal address: pc[1:0] == 0 and pc + 3 < MEM_SIZE (compare in 65 bits, no wrap).
- RUN with illegal pc and no branch: no capture, state -> FAULT, fault = 1. Buffered entries keep draining normally.
- branch_valid (either state): buffer flushed (count 0; a concurrent pop is discarded), pc = branch_target. Target legal -> RUN, fault = 0. Target illegal -> FAULT, fault = 1.
- FAULT: no captures, pc frozen, only branch_valid or reset leaves it.
- reset overrides everything, including a simultaneous branch_valid.

## Timing
- imem_address is a register output; imem_data is sampled on the same edge that advances pc.
- Out of reset: first edge with reset low captures RESET_PC; out_valid = 1 in the following cycle.
- Branch at edge N: out_valid = 0 for the cycle after N; target captured at N+1; out_valid = 1 with out_pc = target after N+1 (1-bubble redirect).
- Steady state with out_ready held high: one instruction per cycle, no bubbles.
- out_ready low: buffer fills to 2 in two edges, pc stalls holding the next unfetched address; outputs stable while out_valid and not out_ready.
- fault rises the edge after the illegal pc is detected, stays high until branch to a legal target or reset.

## Structure
- Shared package: fetch entry type {pc[63:0], instruction[31:0]}, FSM state enum {RUN, FAULT}, default PC_STEP/MEM_SIZE constants shared with the instruction memory.
- One sub-module: fetch_buffer, 2-entry FIFO with push, pop, flush, count, head outputs; synchronous reset.

## Test plan
- Reset release, out_ready = 1, memory words 0x8b1f03e5, 0xf84000a4 at 0x0, 0x4 -> out_pc 0x0 then 0x4 on consecutive cycles, first out_valid one cycle after reset drop.
- Hold out_ready = 0 for 5 cycles -> count 2, imem_address = 0x8 frozen; release -> 0x0, 0x4, 0x8 delivered back-to-back.
- Branch to 0x40 while head pc = 0x4 and out_ready = 1 -> 0x4 not counted as accepted, one bubble, next out_pc = 0x40.
- MEM_SIZE = 16, sequential run -> pcs 0x0..0xC delivered, fault = 1 with pc = 0x10, no further out_valid; branch to 0x0 -> fault = 0, fetch resumes at 0x0.
- Branch to 0x42 (misaligned) -> buffer flushed, fault = 1, out_valid = 0 until next legal branch.
- reset asserted together with branch_valid mid-stream -> pc = RESET_PC, count 0, fault 0, out_valid 0 next cycle.
